// File: rtl/prog_counter.sv
// Up/down counter with a runtime limit, prescaled enable, sync clear/load,
// and wrap or saturate at the limits. tick/tc are registered step strobes.
module prog_counter #(
    parameter int N        = 8,
    parameter int PRESCALE = 1,
    parameter int WRAP     = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         dir,
    input  logic [N-1:0] max_count,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic          step;
    logic          at_term;
    logic [N-1:0]  next_count;

    always_comb begin
        step       = enable && (pre == P_LAST);
        at_term    = 1'b0;
        next_count = count;
        if (dir) begin
            // a count above the limit is treated as terminal and clamped/wrapped
            at_term    = (count >= max_count);
            next_count = at_term ? ((WRAP != 0) ? '0 : max_count) : count + N'(1);
        end else begin
            at_term    = (count == '0);
            next_count = at_term ? ((WRAP != 0) ? max_count : '0) : count - N'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            pre   <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (clear) begin
            count <= '0;
            pre   <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_value;
            pre   <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (enable) begin
            if (step) begin
                count <= next_count;
                pre   <= '0;
                tick  <= 1'b1;
                tc    <= at_term;
            end else begin
                pre   <= pre + PW'(1);
                tick  <= 1'b0;
                tc    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule
